// File: rtl/reg_bank_pkg.sv
// Shared types for the register bank and its I/O sequencer.
// Also provides the address-width helper used by both modules.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_WAIT  = 2'd1,
        OUT_HOLD = 2'd2
    } io_state_t;

    // A single-entry bank still needs one address bit to keep port widths legal.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/reg_bank_io_fsm.sv
// I/O sequencer: decides stall, drives the IN/OUT handshakes, latches the IN destination.
// Latency: OUT and IN each occupy at least two cycles; the stall output is combinational.
// Backpressure: holds the pipeline until out_ack or in_valid arrives.
module reg_bank_io_fsm
    import reg_bank_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              out_req_i,
    input  logic              out_ack_i,
    input  logic              in_req_i,
    input  logic              in_valid_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    output logic              stall_o,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic              out_latch_o,
    output logic              in_wr_o,
    output logic [ADDR_W-1:0] in_addr_o
);

    io_state_t         state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] in_addr_q, in_addr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_addr_q   <= in_addr_d;
        end
    end

    // OUT wins when both requests arrive together; IN is picked up on the next IDLE visit.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        in_addr_d   = in_addr_q;
        case (state_q)
            IDLE: begin
                if (out_req_i) begin
                    state_d     = OUT_HOLD;
                    out_valid_d = 1'b1;
                end else if (in_req_i) begin
                    state_d   = IN_WAIT;
                    in_addr_d = wr_addr_i;
                end
            end
            OUT_HOLD: begin
                if (out_ack_i) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            IN_WAIT: begin
                if (in_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_o     = 1'b0;
        in_ready_o  = 1'b0;
        out_latch_o = 1'b0;
        in_wr_o     = 1'b0;
        case (state_q)
            IDLE: begin
                stall_o     = out_req_i | in_req_i;
                out_latch_o = out_req_i;
            end
            OUT_HOLD: stall_o = ~out_ack_i;
            IN_WAIT: begin
                in_ready_o = 1'b1;
                stall_o    = ~in_valid_i;
                in_wr_o    = in_valid_i;
            end
            default: ;
        endcase
        // Keep the pipeline free while reset is held, even with a request pending.
        if (!rst_ni) begin
            stall_o = 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign in_addr_o   = in_addr_q;

endmodule

// File: rtl/reg_bank_io.sv
// Register file with two async read ports, one write port, optional bypass and zero register.
// Latency: reads combinational, writes land on the next edge; OUT data valid one cycle after request.
// Backpressure: stall freezes the core while IN/OUT waits on the device.
module reg_bank_io
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    localparam int ADDR_W  = addr_width(DEPTH)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              out_req,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ack,
    input  logic              in_req,
    output logic              in_ready,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              stall
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_latch;
    logic              in_wr;
    logic [ADDR_W-1:0] in_addr;
    logic              core_we;
    logic              bank_we;
    logic [ADDR_W-1:0] bank_waddr;
    logic [DATA_W-1:0] bank_wdata;

    // Entry exists and is writable/readable as storage (not the hardwired zero).
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) < DEPTH) && !(ZERO_REG && (a == '0));
    endfunction

    reg_bank_io_fsm #(
        .ADDR_W(ADDR_W)
    ) u_fsm (
        .clk_i      (clock),
        .rst_ni     (resetn),
        .out_req_i  (out_req),
        .out_ack_i  (out_ack),
        .in_req_i   (in_req),
        .in_valid_i (in_valid),
        .wr_addr_i  (wr_addr),
        .stall_o    (stall),
        .in_ready_o (in_ready),
        .out_valid_o(out_valid),
        .out_latch_o(out_latch),
        .in_wr_o    (in_wr),
        .in_addr_o  (in_addr)
    );

    always_comb begin
        rd_data1 = '0;
        if (addr_ok(rd_addr1)) begin
            rd_data1 = (BYPASS && wr_en && (wr_addr == rd_addr1)) ? wr_data : regs_q[rd_addr1];
        end
    end

    always_comb begin
        rd_data2 = '0;
        if (addr_ok(rd_addr2)) begin
            rd_data2 = (BYPASS && wr_en && (wr_addr == rd_addr2)) ? wr_data : regs_q[rd_addr2];
        end
    end

    // The IN completion owns the write port in its cycle; the core write is dropped.
    assign core_we    = wr_en && !stall && !in_wr;
    assign bank_waddr = in_wr ? in_addr : wr_addr;
    assign bank_wdata = in_wr ? in_data : wr_data;
    assign bank_we    = (in_wr || core_we) && addr_ok(bank_waddr);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bank_we) begin
            regs_q[bank_waddr] <= bank_wdata;
        end
    end

    assign out_data_d = out_latch ? rd_data1 : out_data_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_data_q <= '0;
        end else begin
            out_data_q <= out_data_d;
        end
    end

    assign out_data = out_data_q;

endmodule
